// File: rtl/xc_malu_long_seq.sv
// Long-latency multi-cycle ALU sequencer: single-cycle madd/msub through a
// shared external 32-bit adder, and a 32-step shift-add mmul (rs1*rs2+rs3).
module xc_malu_long_seq (
   input  logic        g_clk,
   input  logic        g_reset,
   input  logic        flush,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        op_madd,
   input  logic        op_msub,
   input  logic        op_mmul,
   input  logic [31:0] rs1,
   input  logic [31:0] rs2,
   input  logic [31:0] rs3,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [63:0] rsp_result,
   output logic        busy,
   output logic [31:0] padd_lhs,
   output logic [31:0] padd_rhs,
   output logic        padd_cin,
   output logic        padd_sub,
   input  logic [31:0] padd_result,
   input  logic [31:0] padd_cout
);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

   state_t      state_q, state_d;
   logic [63:0] acc_q;
   logic [31:0] rs2_q;
   logic [4:0]  cnt_q;
   logic [63:0] res_q;
   logic [63:0] mul_nxt;
   logic        is_msub, is_mmul, accept, last_step;

   // Only carry-out of the top bit matters; lower carries are ignored.
   logic        unused_cout;
   assign unused_cout = ^padd_cout[30:0];

   // Anything other than exactly one opcode bit falls back to madd.
   assign is_msub   = op_msub & ~op_madd & ~op_mmul;
   assign is_mmul   = op_mmul & ~op_madd & ~op_msub;

   assign req_ready = (state_q == S_IDLE) & ~g_reset & ~flush;
   assign accept    = req_valid & req_ready;
   assign last_step = (cnt_q == 5'd31);

   // One shift-add step: carry and sum become the new high word, the
   // consumed multiplier bit falls off the bottom.
   assign mul_nxt   = {padd_cout[31], padd_result, acc_q[31:1]};

   assign rsp_result = res_q;

   // State register with synchronous reset.
   always_ff @(posedge g_clk) begin
      if (g_reset) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   // Next-state logic; flush aborts from any state.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (accept)    state_d = is_mmul ? S_MUL : S_DONE;
         S_MUL:  if (last_step) state_d = S_DONE;
         S_DONE: if (rsp_ready) state_d = S_IDLE;
         default:               state_d = S_IDLE;
      endcase
      if (flush) state_d = S_IDLE;
   end

   // Output logic: status flags and adder operand steering.
   always_comb begin
      busy      = (state_q != S_IDLE);
      rsp_valid = (state_q == S_DONE);
      padd_lhs  = '0;
      padd_rhs  = '0;
      padd_cin  = 1'b0;
      padd_sub  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (accept && !is_mmul) begin
               padd_lhs = rs1;
               padd_rhs = rs2;
               padd_sub = is_msub;
               padd_cin = is_msub ? ~rs3[0] : rs3[0];
            end
         end
         S_MUL: begin
            padd_lhs = acc_q[63:32];
            padd_rhs = rs2_q & {32{acc_q[0]}};
         end
         default: ;
      endcase
      if (g_reset) begin
         busy      = 1'b0;
         rsp_valid = 1'b0;
         padd_lhs  = '0;
         padd_rhs  = '0;
         padd_cin  = 1'b0;
         padd_sub  = 1'b0;
      end
   end

   // Datapath: operand capture, multiply iteration and result register.
   always_ff @(posedge g_clk) begin
      if (g_reset) begin
         acc_q <= '0;
         rs2_q <= '0;
         cnt_q <= '0;
         res_q <= '0;
      end else if (accept) begin
         if (is_mmul) begin
            acc_q <= {rs3, rs1};
            rs2_q <= rs2;
            cnt_q <= '0;
         end else if (is_msub) begin
            // High bit reports a borrow, the inverse of the adder carry.
            res_q <= {31'b0, ~padd_cout[31], padd_result};
         end else begin
            res_q <= {31'b0, padd_cout[31], padd_result};
         end
      end else if (state_q == S_MUL && !flush) begin
         acc_q <= mul_nxt;
         cnt_q <= cnt_q + 5'd1;
         if (last_step) res_q <= mul_nxt;
      end
   end

endmodule

// File: tb/tb_xc_malu_long_seq.sv
// Scoreboard bench for xc_malu_long_seq: driver pushes expected results on
// accept, a negedge monitor pops and compares on every presented response.
module tb_xc_malu_long_seq;

   logic        g_clk = 1'b0;
   logic        g_reset, flush, req_valid, req_ready;
   logic        op_madd, op_msub, op_mmul;
   logic [31:0] rs1, rs2, rs3;
   logic        rsp_valid, rsp_ready, busy;
   logic [63:0] rsp_result;
   logic [31:0] padd_lhs, padd_rhs, padd_result, padd_cout;
   logic        padd_cin, padd_sub;

   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   int          rdy_mode = 0;   // 0: always ready, 1: held low, 2: random
   logic        rnd_bit = 1'b1;

   typedef struct {
      logic [63:0] res;
      int          lat;
      int          acc;
   } exp_t;
   exp_t        sb[$];
   logic        seen = 1'b0;
   logic [63:0] held;

   xc_malu_long_seq dut (
      .g_clk(g_clk), .g_reset(g_reset), .flush(flush),
      .req_valid(req_valid), .req_ready(req_ready),
      .op_madd(op_madd), .op_msub(op_msub), .op_mmul(op_mmul),
      .rs1(rs1), .rs2(rs2), .rs3(rs3),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
      .busy(busy),
      .padd_lhs(padd_lhs), .padd_rhs(padd_rhs), .padd_cin(padd_cin),
      .padd_sub(padd_sub), .padd_result(padd_result), .padd_cout(padd_cout)
   );

   always #5 g_clk = ~g_clk;
   always @(posedge g_clk) cyc <= cyc + 1;

   // Random back-pressure source, changed just after each rising edge.
   always @(posedge g_clk) begin
      #1 rnd_bit = ($urandom_range(0, 3) != 0);
   end
   assign rsp_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'b0 : rnd_bit;

   // Shared adder model: ripple carry, cout[i] is the carry out of bit i.
   always_comb begin
      logic c, b;
      c = padd_cin;
      b = 1'b0;
      padd_result = '0;
      padd_cout   = '0;
      for (int i = 0; i < 32; i++) begin
         b = padd_sub ? ~padd_rhs[i] : padd_rhs[i];
         padd_result[i] = padd_lhs[i] ^ b ^ c;
         c = (padd_lhs[i] & b) | (c & (padd_lhs[i] ^ b));
         padd_cout[i] = c;
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%h want=%h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference: plain arithmetic on the operation's meaning.
   function automatic logic [63:0] ref_res(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] c);
      logic [63:0] t;
      if (op == 3'b100)      t = {32'b0, a} * {32'b0, b} + {32'b0, c};
      else if (op == 3'b010) t = ({32'b0, a} - {32'b0, b} - 64'(c[0])) & 64'h1_FFFF_FFFF;
      else                   t = {32'b0, a} + {32'b0, b} + 64'(c[0]);
      return t;
   endfunction

   // op = {mmul, msub, madd}
   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input bit expect_rsp);
      exp_t e;
      int   n;
      {op_mmul, op_msub, op_madd} = op;
      rs1 = a; rs2 = b; rs3 = c;
      req_valid = 1'b1;
      n = 0;
      @(negedge g_clk);
      while (!req_ready && n < 200) begin
         n++;
         @(negedge g_clk);
      end
      if (!req_ready) begin
         chk("req_accept_timeout", 64'(req_ready), 64'd1);
         req_valid = 1'b0;
         return;
      end
      e.acc = cyc;
      e.res = ref_res(op, a, b, c);
      e.lat = (op == 3'b100) ? 33 : 1;
      @(posedge g_clk);
      if (expect_rsp) sb.push_back(e);
      #1 req_valid = 1'b0;
   endtask

   // Monitor: compare the first presentation, then require stability until consumed.
   always @(negedge g_clk) begin
      if (seen && !rsp_valid) begin
         chk("rsp_valid_held", 64'(rsp_valid), 64'd1);
         seen = 1'b0;
      end
      if (rsp_valid) begin
         if (sb.size() == 0) begin
            chk("unexpected_rsp", 64'(rsp_valid), 64'd0);
         end else begin
            if (!seen) begin
               chk("rsp_result", rsp_result, sb[0].res);
               chk("rsp_latency", 64'(cyc - sb[0].acc), 64'(sb[0].lat));
               held = rsp_result;
               seen = 1'b1;
            end else begin
               chk("rsp_stable", rsp_result, held);
            end
            if (rsp_ready) begin
               void'(sb.pop_front());
               seen = 1'b0;
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0]  op;
      logic [31:0] a, b, c;
      int          r, n;
      g_reset = 1'b1; flush = 1'b0; req_valid = 1'b0;
      op_madd = 1'b0; op_msub = 1'b0; op_mmul = 1'b0;
      rs1 = '0; rs2 = '0; rs3 = '0;
      repeat (2) @(posedge g_clk);
      @(negedge g_clk);
      chk("reset_req_ready", 64'(req_ready), 64'd0);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
      @(posedge g_clk); #1 g_reset = 1'b0;
      @(negedge g_clk);
      chk("idle_req_ready", 64'(req_ready), 64'd1);
      chk("idle_rsp_result", rsp_result, 64'd0);
      chk("idle_padd", {padd_lhs, padd_rhs}, 64'd0);
      chk("idle_padd_ctl", {62'd0, padd_cin, padd_sub}, 64'd0);
      @(posedge g_clk); #1;

      // mmul all-ones, busy across the whole operation
      issue(3'b100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
      for (int i = 1; i <= 33; i++) begin
         @(negedge g_clk);
         chk("mmul_busy", 64'(busy), 64'd1);
      end
      @(negedge g_clk);
      chk("mmul_busy_after", 64'(busy), 64'd0);
      @(posedge g_clk); #1;

      // madd carry-out, msub borrow
      issue(3'b001, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b1);
      issue(3'b010, 32'd0, 32'd1, 32'd0, 1'b1);
      repeat (3) @(posedge g_clk); #1;

      // msub with response held off for several cycles
      rdy_mode = 1;
      issue(3'b010, 32'd0, 32'd1, 32'd0, 1'b1);
      repeat (5) begin
         @(negedge g_clk);
         chk("stall_req_ready", 64'(req_ready), 64'd0);
      end
      @(posedge g_clk); #1 rdy_mode = 0;
      repeat (2) @(posedge g_clk); #1;

      // flush mid-multiply, then a fresh madd
      issue(3'b100, 32'd3, 32'd5, 32'd7, 1'b0);
      repeat (9) @(posedge g_clk);
      #1 flush = 1'b1;
      @(negedge g_clk);
      chk("flush_req_ready", 64'(req_ready), 64'd0);
      @(posedge g_clk); #1 flush = 1'b0;
      @(negedge g_clk);
      chk("post_flush_req_ready", 64'(req_ready), 64'd1);
      chk("post_flush_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("post_flush_busy", 64'(busy), 64'd0);
      @(posedge g_clk); #1;
      issue(3'b001, 32'd2, 32'd2, 32'd0, 1'b1);
      repeat (2) @(posedge g_clk); #1;

      // reset mid-multiply
      issue(3'b100, 32'h1234_5678, 32'h9ABC_DEF0, 32'h1111_1111, 1'b0);
      repeat (19) @(posedge g_clk);
      #1 g_reset = 1'b1;
      @(negedge g_clk);
      chk("mreset_outs", {busy, rsp_valid, req_ready, padd_cin, padd_sub}, 64'd0);
      chk("mreset_padd", {padd_lhs, padd_rhs}, 64'd0);
      @(posedge g_clk); #1 g_reset = 1'b0;
      @(negedge g_clk);
      chk("mreset_idle", {busy, rsp_valid, req_ready}, 64'b001);
      chk("mreset_result", rsp_result, 64'd0);
      repeat (3) @(posedge g_clk); #1;

      // random back-to-back stream with random back-pressure
      rdy_mode = 2;
      for (int k = 0; k < 1000; k++) begin
         r = $urandom_range(0, 9);
         if (r < 4)      op = 3'b001;
         else if (r < 7) op = 3'b010;
         else if (r < 9) op = 3'b100;
         else            op = 3'($urandom_range(0, 7));
         a = $urandom; b = $urandom; c = $urandom;
         case ($urandom_range(0, 7))
            0: a = 32'hFFFF_FFFF;
            1: b = 32'hFFFF_FFFF;
            2: begin a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; c = 32'hFFFF_FFFF; end
            3: a = '0;
            default: ;
         endcase
         if (op == 3'b001 || op == 3'b010 || op == 3'b100) ;
         else if (op == 3'b000 && $urandom_range(0, 1) == 1) op = 3'b111;
         issue(op, a, b, c, 1'b1);
         if ($urandom_range(0, 3) == 0) begin
            @(posedge g_clk); #1;
         end
      end
      rdy_mode = 0;
      n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(posedge g_clk);
         n++;
      end
      #1;
      chk("drain_empty", 64'(sb.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/xc_malu_long_seq.md
XC_MALU_LONG_SEQ -- requirements
Module: xc_malu_long_seq

Interface
REQ-001 SHALL have port g_clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port g_reset, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port flush, input, 1 bit: synchronous abort of any in-flight operation.
REQ-004 SHALL have ports req_valid (input, 1) and req_ready (output, 1): request handshake.
REQ-005 SHALL have ports op_madd, op_msub, op_mmul, input, 1 bit each: one-hot opcode, sampled on accept.
REQ-006 SHALL have ports rs1, rs2, rs3, input, 32 bits each: operands, sampled on accept.
REQ-007 SHALL have ports rsp_valid (output, 1) and rsp_ready (input, 1): response handshake.
REQ-008 SHALL have port rsp_result, output, 64 bits: operation result, stable while rsp_valid=1.
REQ-009 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-010 SHALL have ports padd_lhs, padd_rhs (output, 32), padd_cin (output, 1), padd_sub (output, 1): drive the shared adder.
REQ-011 SHALL have ports padd_result (input, 32) and padd_cout (input, 32): adder outputs; padd_cout[31] is carry-out.
REQ-012 SHALL assume this adder contract: padd_result = lhs + (sub ? ~rhs : rhs) + cin, combinational.

Function
REQ-013 SHALL implement states IDLE, MUL, DONE.
REQ-014 SHALL drive req_ready=1 only in IDLE; a request is accepted when req_valid and req_ready are both high.
REQ-015 SHALL treat a request with zero or more than one op bit set as madd.
REQ-016 madd SHALL compute in the accept cycle: lhs=rs1, rhs=rs2, sub=0, cin=rs3[0]; it SHALL register {31'b0, cout[31], sum} and go to DONE.
REQ-017 msub SHALL compute in the accept cycle: lhs=rs1, rhs=rs2, sub=1, cin=~rs3[0], giving rs1-rs2-rs3[0]; it SHALL register {31'b0, ~cout[31], diff} and go to DONE.
REQ-018 On accepting mmul it SHALL load acc={rs3, rs1} and latch rs2, clear the 5-bit count, and go to MUL.
REQ-019 In each MUL cycle it SHALL drive lhs=acc[63:32], rhs=rs2_latched & {32{acc[0]}}, sub=0, cin=0.
REQ-020 In each MUL cycle it SHALL update acc <= {cout[31], padd_result, acc[31:1]} and count <= count+1.
REQ-021 When MUL runs with count=31, it SHALL perform that final step and go to DONE; acc then equals rs1*rs2+rs3, exactly 64-bit with no overflow.
REQ-022 mmul latency SHALL be exactly 33 cycles from the accept edge to the first rsp_valid=1; madd/msub latency SHALL be 1 cycle.
REQ-023 In DONE it SHALL hold rsp_valid=1; when rsp_ready=1 it SHALL return to IDLE on that edge; rsp_ready may already be high on the first DONE cycle.
REQ-024 SHALL NOT accept a new request in the same cycle that a response is consumed; the new request is accepted in the following IDLE cycle.
REQ-025 In IDLE and DONE it SHALL drive padd_lhs, padd_rhs, padd_cin and padd_sub to 0, except in an IDLE accept cycle for madd/msub.
REQ-026 flush=1 SHALL force the next state to IDLE from any state, discard any pending result, and block acceptance that cycle (req_ready=0).
REQ-027 rsp_result SHALL hold its last registered value outside DONE.

Reset
REQ-028 When g_reset=1, it SHALL go to IDLE and clear acc, rs2_latched, count and the result register to 0.
REQ-029 During reset it SHALL drive req_ready=0, rsp_valid=0, busy=0, and all padd outputs to 0.
REQ-030 g_reset SHALL take priority over flush and over any handshake in the same cycle.
REQ-031 Reset asserted mid-MUL SHALL abandon the operation; no response SHALL be produced.

Verification
REQ-032 mmul with rs1=0xFFFFFFFF, rs2=0xFFFFFFFF, rs3=0xFFFFFFFF, rsp_ready=1 -> rsp_result=0xFFFFFFFF00000000 on cycle 33; busy high for cycles 1-33.
REQ-033 madd with rs1=0xFFFFFFFF, rs2=1, rs3=1 -> rsp_result=0x0000000100000001 after 1 cycle.
REQ-034 msub with rs1=0, rs2=1, rs3=0 -> rsp_result=0x00000001FFFFFFFF; repeat with rsp_ready held low for 5 cycles -> rsp_valid and result held stable throughout.
REQ-035 mmul with rs1=3, rs2=5, rs3=7, flush pulsed at MUL cycle 10 -> no rsp_valid, req_ready=1 next cycle; a following madd with rs1=rs2=2, rs3=0 returns 4.
REQ-036 g_reset pulsed at MUL cycle 20 -> next cycle IDLE, all outputs 0, no response; a random back-to-back stream of 1000 ops checked against a reference model with zero mismatches.
